// File: rtl/marie_control_unit.sv
// marie_control_unit: fetch/decode/execute sequencer for the 16-bit MARIE accumulator CPU.
// Owns PC/IR/MBR/AC and drives the synchronous RAM strobes and the external add/subtract ALU.
module marie_control_unit #(
    parameter int                    ADDR_WIDTH   = 14,
    parameter int                    DATA_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = 'h100,
    parameter int                    READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [1:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] ac_out
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, OPRD, EXEC_ALU, WRITE, HALT} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, x;
    logic [DATA_WIDTH-1:0] ir_q, ir_d, mbr_q, mbr_d, ac_q, ac_d;
    logic [1:0] cnt_q, cnt_d, sel_q, sel_d;
    logic cs_q, cs_d, we_q, we_d, oe_q, oe_d, halted_q, halted_d, last, skip, ac_neg, ac_zero;
    logic [3:0] op;
    assign op      = ir_q[DATA_WIDTH-1 -: 4];
    assign x       = ADDR_WIDTH'(ir_q[11:0]);
    assign last    = cnt_q == 2'(READ_LATENCY);
    assign ac_neg  = ac_q[DATA_WIDTH-1];
    assign ac_zero = ac_q == '0;
    assign skip    = ir_q[11:10] == 2'b00 ? ac_neg :
                     ir_q[11:10] == 2'b01 ? ac_zero :
                     ir_q[11:10] == 2'b10 ? !ac_neg && !ac_zero : 1'b0;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mbr_d   = mbr_q;
        ac_d    = ac_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: state_d = start ? FETCH : IDLE;
            FETCH: begin
                if (last) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = DECODE;
                end else cnt_d = cnt_q + 2'd1;
            end
            DECODE: begin
                case (op)
                    4'h1, 4'h3, 4'h4: state_d = OPRD;
                    4'h2:             state_d = WRITE;
                    4'h7:             state_d = HALT;
                    4'h8: begin
                        pc_d    = skip ? pc_q + ADDR_WIDTH'(1) : pc_q;
                        state_d = FETCH;
                    end
                    4'h9: begin
                        pc_d    = x;
                        state_d = FETCH;
                    end
                    4'hA: begin
                        ac_d    = '0;
                        state_d = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            OPRD: begin
                if (last) begin
                    mbr_d   = mem_rdata;
                    ac_d    = op == 4'h1 ? mem_rdata : ac_q;
                    state_d = op == 4'h1 ? FETCH : EXEC_ALU;
                end else cnt_d = cnt_q + 2'd1;
            end
            EXEC_ALU: begin
                ac_d    = alu_out;
                state_d = FETCH;
            end
            WRITE:   state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        // Strobes are registered, so they are derived from the state being entered.
        oe_d     = state_d == FETCH || state_d == OPRD;
        we_d     = state_d == WRITE;
        cs_d     = oe_d || we_d;
        addr_d   = state_d == FETCH ? pc_d : (state_d == OPRD || state_d == WRITE) ? x : '0;
        sel_d    = state_d != EXEC_ALU ? 2'b00 : op == 4'h4 ? 2'b10 : 2'b01;
        halted_d = state_d == HALT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mbr_q    <= '0;
            ac_q     <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            sel_q    <= 2'b00;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mbr_q    <= mbr_d;
            ac_q     <= ac_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            sel_q    <= sel_d;
            halted_q <= halted_d;
        end
    end
    assign mem_addr  = addr_q;
    assign mem_cs    = cs_q;
    assign mem_we    = we_q;
    assign mem_oe    = oe_q;
    assign mem_wdata = ac_q;
    assign alu_a     = ac_q;
    assign alu_b     = mbr_q;
    assign alu_sel   = sel_q;
    assign halted    = halted_q;
    assign pc_out    = pc_q;
    assign ac_out    = ac_q;
endmodule

// File: tb/tb_marie_control_unit.sv
// tb_marie_control_unit: random and directed programs run against an instruction-level model;
// predicted bus/ALU transactions are queued and a negedge monitor pops and compares them.
module tb_marie_control_unit;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_ALU = 2'd2;
    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    sel;
        logic          fetch;
    } item_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
    logic [AW-1:0] mem_addr, pc_out, addr2, pc2;
    logic mem_cs, mem_we, mem_oe, halted, cs2, we2, oe2, halted2;
    logic [DW-1:0] mem_wdata, mem_rdata, alu_a, alu_b, alu_out, ac_out;
    logic [DW-1:0] wdata2, a2, b2, alu_out2, ac2, p2a, p2b;
    logic [1:0] alu_sel, sel2;
    logic ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0, rd_q;
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] mm  [0:(1<<AW)-1];
    item_t exp_q[$];
    item_t mon_it;
    bit mon_ok;
    int rd_left = 0;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] mdl_pc;
    logic [DW-1:0] mdl_ac;
    bit mdl_halt;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    marie_control_unit dut (
        .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_out(alu_out), .halted(halted), .pc_out(pc_out), .ac_out(ac_out)
    );

    marie_control_unit #(.RESET_PC(14'h3FFF), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mem_addr(addr2), .mem_cs(cs2), .mem_we(we2),
        .mem_oe(oe2), .mem_wdata(wdata2), .mem_rdata(p2b), .alu_a(a2), .alu_b(b2),
        .alu_sel(sel2), .alu_out(alu_out2), .halted(halted2), .pc_out(pc2), .ac_out(ac2)
    );

    assign alu_out  = alu_sel == 2'b01 ? alu_a + alu_b : alu_sel == 2'b10 ? alu_a - alu_b : '0;
    assign alu_out2 = sel2 == 2'b01 ? a2 + b2 : sel2 == 2'b10 ? a2 - b2 : '0;
    assign mem_rdata = rd_q;

    function automatic logic [DW-1:0] mem2(input logic [AW-1:0] a);
        return a == 14'h3FFF ? 16'hA000 : 16'h7000;
    endfunction

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] = ld_data;
        else if (mem_cs && mem_we) ram[mem_addr] = mem_wdata;
        rd_q <= ram[mem_addr];
        p2a  <= mem2(addr2);
        p2b  <= p2a;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic [1:0] k, input logic [AW-1:0] ad, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [1:0] s, input logic f);
        item_t it;
        it.kind = k; it.addr = ad; it.a = a; it.b = b; it.sel = s; it.fetch = f;
        return it;
    endfunction

    task automatic take(input logic [1:0] k, output item_t it, output bit ok);
        it = '0;
        ok = 1'b0;
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            chk("access_kind", 32'(k), 32'(it.kind));
            ok = it.kind == k;
        end
    endtask

    always @(negedge clk) begin
        if (rst) rd_left = 0;
        else begin
            if (mem_cs && mem_oe) begin
                if (rd_left == 0) begin
                    take(K_RD, mon_it, mon_ok);
                    if (mon_ok) begin
                        chk("rd_addr", 32'(mem_addr), 32'(mon_it.addr));
                        if (mon_it.fetch) begin
                            chk("fetch_pc", 32'(pc_out), 32'(mon_it.addr));
                            chk("fetch_ac", 32'(ac_out), 32'(mon_it.a));
                        end
                    end
                    rd_left = 1;
                    rd_addr = mem_addr;
                end else begin
                    chk("rd_hold_addr", 32'(mem_addr), 32'(rd_addr));
                    rd_left--;
                end
            end else if (rd_left != 0) begin
                chk("rd_hold_strobe", 32'({mem_cs, mem_oe}), 32'd3);
                rd_left = 0;
            end
            if (mem_we) begin
                chk("we_with_oe", 32'({mem_cs, mem_oe}), 32'd2);
                take(K_WR, mon_it, mon_ok);
                if (mon_ok) begin
                    chk("wr_addr", 32'(mem_addr), 32'(mon_it.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(mon_it.a));
                end
            end
            if (alu_sel != 2'b00) begin
                take(K_ALU, mon_it, mon_ok);
                if (mon_ok) begin
                    chk("alu_sel", 32'(alu_sel), 32'(mon_it.sel));
                    chk("alu_a", 32'(alu_a), 32'(mon_it.a));
                    chk("alu_b", 32'(alu_b), 32'(mon_it.b));
                end
            end
        end
    end

    // Instruction-level reference: executes the program in mm and queues every bus/ALU event.
    task automatic mdl_run();
        logic [AW-1:0] pc, x;
        logic [DW-1:0] ac, ir, opd;
        logic c;
        pc = 14'h100;
        ac = '0;
        mdl_halt = 1'b0;
        for (int k = 0; k < 500 && !mdl_halt; k++) begin
            ir = mm[pc];
            x  = {2'b00, ir[11:0]};
            exp_q.push_back(mk(K_RD, pc, ac, '0, 2'b00, 1'b1));
            pc = pc + 14'd1;
            case (ir[15:12])
                4'h1: begin
                    exp_q.push_back(mk(K_RD, x, '0, '0, 2'b00, 1'b0));
                    ac = mm[x];
                end
                4'h2: begin
                    exp_q.push_back(mk(K_WR, x, ac, '0, 2'b00, 1'b0));
                    mm[x] = ac;
                end
                4'h3, 4'h4: begin
                    opd = mm[x];
                    exp_q.push_back(mk(K_RD, x, '0, '0, 2'b00, 1'b0));
                    exp_q.push_back(mk(K_ALU, '0, ac, opd, ir[15:12] == 4'h3 ? 2'b01 : 2'b10, 1'b0));
                    ac = ir[15:12] == 4'h3 ? ac + opd : ac - opd;
                end
                4'h7: mdl_halt = 1'b1;
                4'h8: begin
                    c = ir[11:10] == 2'd0 ? $signed(ac) < 0 : ir[11:10] == 2'd1 ? ac == 0 :
                        ir[11:10] == 2'd2 ? $signed(ac) > 0 : 1'b0;
                    if (c) pc = pc + 14'd1;
                end
                4'h9: pc = x;
                4'hA: ac = '0;
                default: ;
            endcase
        end
        mdl_pc = pc;
        mdl_ac = ac;
    endtask

    task automatic clear_mm();
        for (int a = 'h100; a < 'h120; a++) mm[a] = '0;
        for (int a = 'h200; a < 'h210; a++) mm[a] = '0;
        mm['h050] = '0;
    endtask

    task automatic put(input int a);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = mm[a];
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic load_mem();
        for (int a = 'h100; a < 'h120; a++) put(a);
        for (int a = 'h200; a < 'h210; a++) put(a);
        put('h050);
    endtask

    task automatic reset_load_start();
        @(posedge clk); #1 rst = 1'b1;
        load_mem();
        mdl_run();
        @(posedge clk); #1 rst = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_prog();
        reset_load_start();
        for (int c = 0; c < 3000 && !halted; c++) @(negedge clk);
        @(negedge clk);
        chk("halted", 32'(halted), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("final_pc", 32'(pc_out), 32'(mdl_pc));
        chk("final_ac", 32'(ac_out), 32'(mdl_ac));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("halt_sticky", 32'({halted, mem_cs}), 32'd2);
        chk("halt_pc_frozen", 32'(pc_out), 32'(mdl_pc));
        for (int a = 'h200; a < 'h210; a++) chk("ram_data", 32'(ram[a]), 32'(mm[a]));
        chk("ram_050", 32'(ram['h050]), 32'(mm['h050]));
        chk("ram_10d", 32'(ram['h10D]), 32'(mm['h10D]));
        exp_q.delete();
    endtask

    task automatic test_wrap();
        int hold, c;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            c = 0;
            @(negedge clk);
            while (!(cs2 && oe2) && c < 20) begin c++; @(negedge clk); end
            chk("wrap_fetch_addr", 32'(addr2), k == 0 ? 32'h3FFF : 32'h0);
            hold = 0;
            while (cs2 && oe2 && hold < 8) begin hold++; @(negedge clk); end
            chk("wrap_fetch_hold", 32'(hold), 32'd3);
        end
        c = 0;
        while (!halted2 && c < 20) begin c++; @(negedge clk); end
        chk("wrap_halted", 32'(halted2), 32'd1);
        chk("wrap_ac", 32'(ac2), 32'd0);
        chk("wrap_pc", 32'(pc2), 32'd1);
    endtask

    task automatic gen_random();
        int r, t, n;
        logic [11:0] xd;
        n = 18;
        clear_mm();
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 5);
            mm['h200 + i] = r == 0 ? 16'h0000 : r == 1 ? 16'h8000 : r == 2 ? 16'h7FFF :
                            r == 3 ? 16'hFFFF : 16'($urandom);
        end
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 9);
            xd = 12'h200 + 12'($urandom_range(0, 15));
            t  = i + 1 + $urandom_range(0, 3);
            t  = t > n ? n : t;
            case (r)
                0, 8: mm['h100 + i] = {4'h1, xd};
                1, 9: mm['h100 + i] = {4'h3, xd};
                2:    mm['h100 + i] = {4'h4, xd};
                3:    mm['h100 + i] = {4'h2, xd};
                4:    mm['h100 + i] = {4'h8, 2'($urandom_range(0, 3)), 10'($urandom)};
                5:    mm['h100 + i] = {4'h9, 12'('h100 + t)};
                6:    mm['h100 + i] = {4'hA, 12'($urandom)};
                default: begin
                    r = $urandom_range(0, 7);
                    mm['h100 + i] = {4'(r == 0 ? 0 : r <= 2 ? r + 4 : r + 8), 12'($urandom)};
                end
            endcase
        end
        mm['h100 + n] = 16'h7000;
        mm['h101 + n] = 16'h7000;
    endtask

    initial begin
        logic [DW-1:0] mul [16];
        mul = '{16'h110C, 16'h210E, 16'h110D, 16'h310B, 16'h210D, 16'h110E, 16'h310F, 16'h210E,
                16'h8400, 16'h9102, 16'h7000, 16'h0005, 16'h0007, 16'h0000, 16'h0000, 16'hFFFF};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_wrap();
        clear_mm();
        for (int i = 0; i < 16; i++) mm['h100 + i] = mul[i];
        run_prog();
        chk("multiply_result", 32'(ram['h10D]), 32'h0023);
        clear_mm();
        mm['h200] = 16'h8000;
        mm['h100] = 16'h1200; mm['h101] = 16'h8000; mm['h102] = 16'h7000;
        mm['h103] = 16'h8800; mm['h104] = 16'hA000; mm['h105] = 16'h7000;
        run_prog();
        clear_mm();
        mm['h201] = 16'hBEEF;
        mm['h100] = 16'h1201; mm['h101] = 16'h2050; mm['h102] = 16'h7000;
        run_prog();
        chk("store_beef", 32'(ram['h050]), 32'hBEEF);
        clear_mm();
        mm['h202] = 16'h0003; mm['h203] = 16'h0005;
        mm['h100] = 16'h1202; mm['h101] = 16'h4203; mm['h102] = 16'h7000;
        run_prog();
        chk("subt_ac", 32'(ac_out), 32'hFFFE);
        clear_mm();
        mm['h200] = 16'h1234;
        mm['h100] = 16'h1200; mm['h101] = 16'h7000;
        reset_load_start();
        begin
            int c = 0;
            @(negedge clk);
            while (!(mem_cs && mem_oe && mem_addr == 14'h101) && c < 50) begin c++; @(negedge clk); end
            chk("abort_reach_fetch", 32'(mem_addr), 32'h101);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_strobes", 32'({mem_cs, mem_oe, mem_we, halted}), 32'd0);
        chk("abort_pc", 32'(pc_out), 32'h100);
        chk("abort_ac", 32'(ac_out), 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("abort_idle", 32'({mem_cs, pc_out}), 32'h100);
        for (int p = 0; p < 10; p++) begin
            gen_random();
            run_prog();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
